signed_seq_divider: RTL and testbench
=====================================

Name: signed_seq_divider

Overview:
Multi-cycle signed integer divider controller. It sequences a restoring shift/subtract datapath one quotient bit per clock, then applies sign correction with truncation toward zero. It sits beside the combinational divide-by-2 shifter blocks. Arbitrary divisors are served here through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement), minimum 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
dividend  input  WIDTH  signed dividend, sampled with start
divisor  input  WIDTH  signed divisor, sampled with start
busy  output  1  high while an operation is in progress (state != IDLE)
done  output  1  one-cycle pulse: results valid
quotient  output  WIDTH  signed quotient, held until next done
remainder  output  WIDTH  signed remainder, held until next done
div_by_zero  output  1  flag for last result, held until next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers and iteration counter cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- FSM states:
  - IDLE: busy=0. On an edge with start=1 and divisor!=0: latch |dividend|, |divisor| as unsigned WIDTH-bit magnitudes, plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); clear the partial remainder; count=0; go to CALC.
  - IDLE with start=1 and divisor=0: go to FIX with the zero flag set.
  - CALC: each edge performs one restoring step. Shift {partial remainder, dividend magnitude} left by 1; trial subtract the divisor magnitude (WIDTH+1-bit subtraction); if non-negative, keep the difference and set the quotient LSB to 1, else restore and set it to 0. count increments; after WIDTH steps (count=WIDTH-1 on the edge) go to FIX.
  - FIX: one edge. Register quotient = sign_q ? -q_mag : q_mag and remainder = sign_r ? -r_mag : r_mag (WIDTH-bit wrap). Set div_by_zero=0 and done<=1, then go to IDLE.
  - FIX with the zero flag set: quotient={WIDTH{1'b1}}, remainder=dividend as latched, div_by_zero=1, done<=1.
- Timing:
  - done is high for exactly one cycle, the cycle after the FIX edge; it clears on the next edge.
  - Latency from the start-sampling edge to done high is WIDTH+1 edges (1 edge for divide-by-zero).
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - start in the same cycle as done=1 is accepted, since the state is already IDLE (back-to-back operation).
  - Operands are only sampled on the accepting edge; later input changes have no effect.
- Arithmetic:
  - Truncating division: dividend = quotient*divisor + remainder, |remainder| < |divisor|, and remainder carries the dividend's sign.
  - Overflow: -2^(WIDTH-1) / -1 gives quotient = -2^(WIDTH-1) (wraps) and remainder=0; no overflow flag.
  - |−2^(WIDTH-1)| is held correctly as an unsigned WIDTH-bit magnitude.
- Outputs quotient/remainder/div_by_zero change only on the FIX edge.

Decomposition:
- Shared package/header div_pkg:
  - state encoding localparams (IDLE, CALC, FIX);
  - the counter width function clog2(WIDTH).
- One natural combinational sub-module, div_sign_fix: takes magnitudes and sign bits and produces the signed quotient/remainder. It is instantiated once, in the FIX path.
- Controller, counter and datapath registers stay in signed_seq_divider.

Test Plan:
- WIDTH=8, 100/7 → done after 9 edges; quotient=14 (0x0E), remainder=2, div_by_zero=0; busy high for exactly 9 cycles.
- -100/7 → quotient=0xF2 (-14), remainder=0xFE (-2); 100/-7 → quotient=0xF2, remainder=0x02; -100/-7 → quotient=0x0E, remainder=0xFE.
- -128/-1 → quotient=0x80, remainder=0x00; -128/1 → quotient=0x80, remainder=0; 3/5 → quotient=0, remainder=3.
- 5/0 → done after 1 edge; quotient=0xFF, remainder=0x05, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero cleared.
- Start 50/3, pulse start again with 1/1 at cycle 3 → ignored; result quotient=16, remainder=2. Assert start with 20/4 during the done cycle → accepted; second done exactly 9 edges later with quotient=5, remainder=0.
- Start 100/7, assert rst_n=0 at cycle 4 → all outputs 0 immediately (async), no done pulse. After release, 7/2 → quotient=3, remainder=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the iteration-counter width helper.
package div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter must hold 0..n-1; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Applies the result signs to unsigned quotient/remainder magnitudes
// (truncation toward zero; remainder follows the dividend's sign).
module div_sign_fix #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q_mag,
    input  logic [WIDTH-1:0] i_r_mag,
    input  logic             i_sign_q,
    input  logic             i_sign_r,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    always_comb begin
        o_quotient  = i_sign_q ? (~i_q_mag + 1'b1) : i_q_mag;
        o_remainder = i_sign_r ? (~i_r_mag + 1'b1) : i_r_mag;
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider: restoring shift/subtract, one quotient bit per
// clock, followed by a single sign-correction cycle.
module signed_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state, w_next;
    logic [WIDTH-1:0] r_q_mag, r_rem, r_dsr, r_dvd_raw;
    logic             r_sign_q, r_sign_r, r_zero;
    logic [CW-1:0]    r_cnt;
    logic             r_done, r_dbz;
    logic [WIDTH-1:0] r_quot, r_remo;

    logic             w_busy, w_load;
    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_neg;
    logic [WIDTH-1:0] w_quot_fix, w_rem_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = (divisor == '0) ? FIX : CALC;
            CALC: if (r_cnt == LAST) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy = (r_state != IDLE);
        w_load = (r_state == IDLE) && start;
    end

    // Partial remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
    // so the shifted value's top bit is clear and bit WIDTH of the difference
    // is a valid borrow.
    always_comb begin
        w_shift = {r_rem, r_q_mag[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dsr};
        w_neg   = w_diff[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_mag   <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_dvd_raw <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
        end else if (w_load) begin
            r_q_mag   <= dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
            r_dsr     <= divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
            r_dvd_raw <= dividend;
            r_sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r  <= dividend[WIDTH-1];
            r_zero    <= (divisor == '0);
            r_rem     <= '0;
            r_cnt     <= '0;
        end else if (r_state == CALC) begin
            r_rem   <= w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q_mag <= {r_q_mag[WIDTH-2:0], ~w_neg};
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_q_mag     (r_q_mag),
        .i_r_mag     (r_rem),
        .i_sign_q    (r_sign_q),
        .i_sign_r    (r_sign_r),
        .o_quotient  (w_quot_fix),
        .o_remainder (w_rem_fix)
    );

    // Result registers only move on the FIX edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (r_state == FIX) begin
                r_quot <= r_zero ? '1 : w_quot_fix;
                r_remo <= r_zero ? r_dvd_raw : w_rem_fix;
                r_dbz  <= r_zero;
            end
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (WIDTH=8): directed cases,
// handshake corner cases and randomized operands against a behavioural model.
module tb_signed_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: truncating signed division on plain integers.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
        end
    endfunction

    // Entered at a negedge; issues one start, returns at the negedge where done
    // is seen (lat = edges after the accepting edge, -1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at,
                          output int lat, output int bcnt);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = ~a; divisor = 8'h01;
        lat = 0; bcnt = 0;
        @(negedge clk);
        if (busy) bcnt++;
        while (lat < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            if (lat == pulse_at) begin start = 1'b1; dividend = 8'h01; divisor = 8'h01; end
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd3};
        logic [W-1:0] tb [7] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'h01, 8'd5};
        logic [W-1:0] tq [7] = '{8'h0E,  8'hF2, 8'hF2,  8'h0E, 8'h80, 8'h80, 8'h00};
        logic [W-1:0] tr [7] = '{8'h02,  8'hFE, 8'h02,  8'hFE, 8'h00, 8'h00, 8'h03};
        int lat, bcnt;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], -1, lat, bcnt);
            checks++;
            if (lat !== 9 || bcnt !== 9) begin
                errors++;
                $display("FAIL dir%0d_timing: got lat=%0d busy_cycles=%0d, want 9 9", i, lat, bcnt);
            end
            checks++;
            if (quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=0",
                         i, quotient, remainder, div_by_zero, tq[i], tr[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || quotient !== tq[i]) begin
                errors++;
                $display("FAIL dir%0d_done_pulse: got done=%b q=%h, want done=0 q=%h",
                         i, done, quotient, tq[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        run_op(8'd5, 8'd0, -1, lat, bcnt);
        checks++;
        if (lat !== 1 || quotient !== 8'hFF || remainder !== 8'h05 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d q=%h r=%h dbz=%b, want 1 ff 05 1",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        run_op(8'd9, 8'd3, -1, lat, bcnt);
        checks++;
        if (lat !== 9 || quotient !== 8'h03 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_zero: got lat=%0d q=%h r=%h dbz=%b, want 9 03 00 0",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(8'd50, 8'd3, 3, lat, bcnt);
        checks++;
        if (lat !== 9 || quotient !== 8'd16 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%h r=%h, want 9 10 02",
                     lat, quotient, remainder);
        end
        // Still in the done cycle: this start must be accepted.
        run_op(8'd20, 8'd4, -1, lat, bcnt);
        checks++;
        if (lat !== 9 || quotient !== 8'd5 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d q=%h r=%h, want 9 05 00",
                     lat, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, seen;
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        seen = 0;
        repeat (3) begin @(negedge clk); if (done) seen++; end
        rst_n = 1'b1;
        repeat (10) begin @(negedge clk); if (done || busy) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d cycles with done/busy, want 0", seen);
        end
        run_op(8'd7, 8'd2, -1, lat, bcnt);
        checks++;
        if (lat !== 9 || quotient !== 8'd3 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d q=%h r=%h, want 9 03 01",
                     lat, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic ez;
        int lat, bcnt;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom_range(0, 255));
            if (i == 0) begin a = 8'h80; b = 8'h80; end
            if (i == 1) begin a = 8'h7F; b = 8'h80; end
            ref_div(a, b, eq, er, ez);
            run_op(a, b, -1, lat, bcnt);
            checks++;
            if (lat !== (ez ? 1 : 9) || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL rand%0d %h/%h: got lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=%h r=%h dbz=%b",
                         i, a, b, lat, quotient, remainder, div_by_zero, ez ? 1 : 9, eq, er, ez);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
